// File: rtl/comp_pkg.sv
//------------------------------------------------------------------------------
// Module : comp_pkg
// Brief  : Shared types for the sequential comparator (FSM states, slice codes).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package comp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [1:0] res_t;

    localparam res_t RES_EQ = 2'd0;
    localparam res_t RES_GT = 2'd1;
    localparam res_t RES_LT = 2'd2;

endpackage : comp_pkg

`default_nettype wire

// File: rtl/comp_2bit.sv
//------------------------------------------------------------------------------
// Module : comp_2bit
// Brief  : Combinational 2-bit magnitude comparator slice, encoded result.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module comp_2bit
    import comp_pkg::*;
(
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output res_t       o_res
);

    always_comb begin
        o_res = RES_EQ;
        if (i_a > i_b) begin
            o_res = RES_GT;
        end else if (i_a < i_b) begin
            o_res = RES_LT;
        end
    end

endmodule : comp_2bit

`default_nettype wire

// File: rtl/comp_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : comp_seq_ctrl
// Brief  : Sequential WIDTH-bit magnitude comparator, MSB slice first, early exit.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module comp_seq_ctrl
    import comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N_SLICE = WIDTH / 2;
    localparam int IDX_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
    localparam int N_PAD   = 1 << IDX_W;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [WIDTH-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
    logic               r_done, r_gt, r_eq, r_lt;
    logic               w_done_nxt, w_gt_nxt, w_eq_nxt, w_lt_nxt;
    logic [1:0]         w_a_arr [N_PAD];
    logic [1:0]         w_b_arr [N_PAD];
    res_t               w_res;

    // Slice table padded to a power of two so idx indexes it at full width
    for (genvar gi = 0; gi < N_PAD; gi++) begin : g_slice
        if (gi < N_SLICE) begin : g_used
            assign w_a_arr[gi] = r_a[2*gi +: 2];
            assign w_b_arr[gi] = r_b[2*gi +: 2];
        end else begin : g_pad
            assign w_a_arr[gi] = 2'b00;
            assign w_b_arr[gi] = 2'b00;
        end
    end

    comp_2bit u_comp_2bit (
        .i_a   (w_a_arr[r_idx]),
        .i_b   (w_b_arr[r_idx]),
        .o_res (w_res)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_done_nxt  = 1'b0;
        w_gt_nxt    = r_gt;
        w_eq_nxt    = r_eq;
        w_lt_nxt    = r_lt;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_idx_nxt   = IDX_W'(N_SLICE - 1);
                    w_gt_nxt    = 1'b0;
                    w_eq_nxt    = 1'b0;
                    w_lt_nxt    = 1'b0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                case (w_res)
                    RES_GT: begin
                        w_gt_nxt    = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                    RES_LT: begin
                        w_lt_nxt    = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                    default: begin
                        if (r_idx == '0) begin
                            w_eq_nxt    = 1'b1;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_idx_nxt = r_idx - IDX_W'(1);
                        end
                    end
                endcase
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_done  <= w_done_nxt;
            r_gt    <= w_gt_nxt;
            r_eq    <= w_eq_nxt;
            r_lt    <= w_lt_nxt;
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign gt   = r_gt;
    assign eq   = r_eq;
    assign lt   = r_lt;

endmodule : comp_seq_ctrl

`default_nettype wire

// File: tb/tb_comp_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_comp_seq_ctrl
// Brief  : Directed self-checking bench for comp_seq_ctrl (WIDTH=8 and WIDTH=2).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_comp_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, gt, eq, lt;
    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, gt2, eq2, lt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    comp_seq_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    comp_seq_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .gt(gt2), .eq(eq2), .lt(lt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request; expect the result {gt,eq,lt}=exp_res after exp_k edges
    task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input int exp_k, input logic [2:0] exp_res);
        int k;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_flags_busy"}, {gt, eq, lt}, 3'b000);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_k"}, k, exp_k);
        chk({tag, "_res"}, {gt, eq, lt}, exp_res);
        chk({tag, "_busy_done"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_res_held"}, {gt, eq, lt}, exp_res);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        chk("rst_out", {busy, done, gt, eq, lt}, 5'b0);
        rst_n = 1'b1;

        // 1. reset mid-RUN
        @(negedge clk);
        a = 8'h3C; b = 8'h3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t1_busy", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t1_async_rst", {busy, done, gt, eq, lt}, 5'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) k++;
        end
        chk("t1_no_done", k, 0);
        run_cmp("t1_post", 8'hA5, 8'h5A, 1, 3'b100);

        // 2. full-length equal; 3. LSB decision
        run_cmp("t2_eq", 8'h3C, 8'h3C, 4, 3'b010);
        run_cmp("t3_lsb", 8'h12, 8'h13, 4, 3'b001);

        // 4. mid early exit with noise on a/b/start while busy
        @(negedge clk);
        a = 8'h4F; b = 8'h70; start = 1'b1;
        @(negedge clk);
        chk("t4_busy", busy, 1'b1);
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_still_busy", {busy, done}, 2'b10);
        @(negedge clk);
        chk("t4_done", done, 1'b1);
        chk("t4_res", {gt, eq, lt}, 3'b001);

        // 5. back-to-back with start held across done
        @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        a = 8'h00; b = 8'h01;
        chk("t5_busy1", busy, 1'b1);
        @(negedge clk);
        chk("t5_done1", done, 1'b1);
        chk("t5_res1", {gt, eq, lt}, 3'b100);
        @(negedge clk);
        start = 1'b0;
        chk("t5_accept", {busy, done, gt, eq, lt}, 5'b10000);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t5_k2", k, 4);
        chk("t5_res2", {gt, eq, lt}, 3'b001);

        // 6. WIDTH=2 exhaustive sweep
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                a2 = 2'(i); b2 = 2'(j); start2 = 1'b1;
                @(negedge clk);
                start2 = 1'b0;
                chk("t6_busy", {busy2, done2}, 2'b10);
                @(negedge clk);
                chk("t6_done_k1", {busy2, done2}, 2'b01);
                chk("t6_res", {gt2, eq2, lt2}, {i > j, i == j, i < j});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_comp_seq_ctrl

`default_nettype wire
